lwbuf_stream_reader: RTL
========================

Name: lwbuf_stream_reader

Overview:
- FPGA-fabric master for port 2 of the 1024x32 dual-port LW H2F buffer RAM.
- The HPS fills the buffer through the LW bridge on port 1. On a start command, this block reads a window of words through port 2 and emits them on an Avalon-ST source with backpressure.
- After the last word is accepted downstream, it writes a completion word back into the buffer so the HPS can poll it.

Parameters:
- ADDR_W, 10, buffer word-address width (depth 2**ADDR_W).
- DATA_W, 32, buffer and stream data width.
- STATUS_ADDR, 1023, buffer word address that receives the completion word.

Ports:
- clk  in  1  single clock, shared with the buffer RAM.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; honoured only in IDLE.
- base  in  ADDR_W  first word address, sampled on start.
- len  in  ADDR_W+1  word count 0..1024, sampled on start.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the completion word is written.
- address2  out  ADDR_W  buffer port-2 address.
- chipselect2  out  1  buffer port-2 select.
- write2  out  1  buffer port-2 write.
- byteenable2  out  DATA_W/8  always all ones.
- writedata2  out  DATA_W  buffer port-2 write data.
- clken2  out  1  tied high.
- readdata2  in  DATA_W  buffer port-2 read data.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready.
- st_sop  out  1  first word of the burst.
- st_eop  out  1  last word of the burst.

Behaviour:
- Reset values: busy=0, done=0, chipselect2=0, write2=0, address2=0, writedata2=0, st_valid=0, st_sop=0, st_eop=0, st_data=0. Every state register is cleared asynchronously on reset_n low.
- Buffer read timing: fixed latency 1. The address is registered inside the RAM and the output is unregistered, so readdata2 is valid in the cycle after a cycle with chipselect2=1 and write2=0.
- FSM states: IDLE, READ, DRAIN, WB, FIN.
- IDLE:
  - start=1 latches base into rd_ptr, len into issue_cnt and out_cnt, and sets busy=1.
  - If len=0, go to WB. Otherwise go to READ.
  - start while busy is ignored and has no side effects.
- READ:
  - A read is issued (chipselect2=1, address2=rd_ptr) only if issue_cnt>0 and the 2-entry output FIFO has at least one free slot after counting the read in flight.
  - On issue: rd_ptr increments modulo 2**ADDR_W (1023 wraps to 0) and issue_cnt decrements.
  - The word returned one cycle later is pushed into the FIFO.
  - When issue_cnt reaches 0, go to DRAIN.
- Stream output:
  - The FIFO head drives st_data and st_valid.
  - A word is transferred when st_valid and st_ready are both 1; out_cnt then decrements.
  - st_sop=1 on the first word of the burst. st_eop=1 when out_cnt=1.
  - While st_valid=1, st_data, st_sop and st_eop must hold stable until accepted.
  - With st_ready held high, the sustained rate is one word per cycle after the first.
- DRAIN: wait until out_cnt=0, then go to WB.
- WB:
  - Drive one write cycle: chipselect2=1, write2=1, address2=STATUS_ADDR, writedata2 = {1'b1, zeros, len_latched[ADDR_W:0]}. For len=1024 this is 0x80000400.
  - Go to FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Port 2 issues no accesses outside READ and WB.
- The reader does not arbitrate against HPS writes to the same address. The RAM's mixed-port old-data rule applies; software must not write the window while busy=1.
- Asynchronous reset mid-burst: abandons the burst, no completion word is written, and all outputs return to their reset values.

Test Plan:
- Preload buffer[0..3]=0x11,0x22,0x33,0x44; start base=0 len=4; st_ready=1 -> st_data 0x11..0x44 on consecutive cycles, sop on 0x11, eop on 0x44; buffer[1023]=0x80000004; one done pulse.
- base=1022 len=4 with buffer[1022]=A, [1023]=B, [0]=C, [1]=D -> stream A,B,C,D (wrap-around). The completion write then overwrites [1023] with 0x80000004.
- len=4, st_ready toggling 1,0,0,1,0,1... -> no word lost or duplicated, data held while stalled, at most 2 reads outstanding beyond accepted words.
- start with len=0 -> no stream beats, one write of 0x80000000 to 1023, done two cycles after start.
- Second start pulse during a len=8 burst -> ignored; exactly 8 beats and one done.
- reset_n asserted after the 3rd beat of a len=8 burst -> outputs go to reset values immediately, no write to 1023; a new start after release behaves normally.

Source files
------------

// File: rtl/lwbuf_stream_reader.sv
// Port-2 master for the LW H2F buffer RAM: streams a window of words out on an
// Avalon-ST source, then writes a completion word back for the HPS to poll.
module lwbuf_stream_reader #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int STATUS_ADDR = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     address2,
    output logic                  chipselect2,
    output logic                  write2,
    output logic [DATA_W/8-1:0]   byteenable2,
    output logic [DATA_W-1:0]     writedata2,
    output logic                  clken2,
    input  logic [DATA_W-1:0]     readdata2,
    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_sop,
    output logic                  st_eop
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int PAD_W = DATA_W - 1 - CNT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WB,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  len_q;
    logic              rd_pending;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_wr_idx;
    logic              fifo_rd_idx;
    logic [1:0]        fifo_cnt;

    logic              start_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2:0]        occ_after;
    logic [DATA_W-1:0] status_word;

    assign start_ok = (state == S_IDLE) && start;
    assign push     = rd_pending;
    assign pop      = st_valid && st_ready;

    // Slots claimed once this cycle's pop is retired; a new read needs one free.
    assign occ_after = {1'b0, fifo_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue     = (state == S_READ) && (issue_cnt != '0) && (occ_after < 3'd2);

    assign status_word = {1'b1, {PAD_W{1'b0}}, len_q};

    assign st_valid = (fifo_cnt != 2'd0);
    assign st_data  = fifo_mem[fifo_rd_idx];
    // Both flags depend only on out_cnt, which moves only on acceptance, so they hold while stalled.
    assign st_sop   = st_valid && (out_cnt == len_q);
    assign st_eop   = st_valid && (out_cnt == CNT_W'(1));

    assign byteenable2 = '1;
    assign clken2      = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? S_WB : S_READ;
                end
            end
            S_READ: begin
                if (issue && (issue_cnt == CNT_W'(1))) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt == '0) begin
                    state_next = S_WB;
                end
            end
            S_WB:    state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_FIN);
        chipselect2 = 1'b0;
        write2      = 1'b0;
        address2    = '0;
        writedata2  = '0;
        if (state == S_WB) begin
            chipselect2 = 1'b1;
            write2      = 1'b1;
            address2    = ADDR_W'(STATUS_ADDR);
            writedata2  = status_word;
        end else if (issue) begin
            chipselect2 = 1'b1;
            address2    = rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            issue_cnt  <= '0;
            out_cnt    <= '0;
            len_q      <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (start_ok) begin
                rd_ptr    <= base;
                issue_cnt <= len;
                out_cnt   <= len;
                len_q     <= len;
            end else begin
                if (issue) begin
                    rd_ptr    <= rd_ptr + ADDR_W'(1);
                    issue_cnt <= issue_cnt - CNT_W'(1);
                end
                if (pop) begin
                    out_cnt <= out_cnt - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the two FIFO entries are reset too, so st_data reads zero after reset like every other output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wr_idx <= 1'b0;
            fifo_rd_idx <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_idx] <= readdata2;
                fifo_wr_idx           <= ~fifo_wr_idx;
            end
            if (pop) begin
                fifo_rd_idx <= ~fifo_rd_idx;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
